flash_cache_controller: RTL and testbench
=========================================

// Module: flash_cache_controller
// PURPOSE
//  Fully associative, read-only line cache between the CPU instruction/data fetch port and the flash
//  line-fetch engine. Does the tag lookup and victim selection, and sequences line refills.
//  Drives the binary-tree PLRU replacement sub-module: sends the touched way, takes the LRU way back.
//  Hits answer in 1 cycle; misses fetch a whole line from flash, then answer.
// PARAMETERS
//  WAY_BITS        3   log2 number of lines (ways); PLRU SIZE = WAY_BITS
//  LINE_WORD_BITS  2   log2 32-bit words per line (4 words = 16 B)
//  ADDR_WIDTH      24  byte address width
// PORTS
//  clk          in   1               clock, all state on rising edge
//  rst          in   1               reset, synchronous, active-high
//  cpu_req      in   1               read request, level, held until cpu_ack
//  cpu_addr     in   ADDR_WIDTH      byte address; [1:0] ignored; stable while cpu_req
//  cpu_rdata    out  32              read word, valid with cpu_ack
//  cpu_ack      out  1               1-cycle pulse, request complete
//  flush        in   1               invalidate all lines (pulse)
//  fetch_req    out  1               line fetch request, held until last beat
//  fetch_addr   out  ADDR_WIDTH      line-aligned byte address, stable while fetch_req
//  fetch_data   in   32              refill word
//  fetch_valid  in   1               one refill beat, words arrive in order 0..N-1
//  busy         out  1               high in any state other than IDLE
// BEHAVIOUR
//  Reset: all valid bits 0, state IDLE, cpu_ack=0, fetch_req=0, cpu_rdata=0, busy=0; PLRU state reset.
//  Fields: word = addr[LINE_WORD_BITS+1:2]; tag = addr[ADDR_WIDTH-1:LINE_WORD_BITS+2].
//  States: IDLE -> FETCH -> RESPOND -> IDLE.
//  IDLE, cpu_req=1: compare tag against all valid ways in one cycle (at most one can match).
//   Hit: register data[hit_way][word] into cpu_rdata; cpu_ack=1 next cycle; pulse PLRU enable
//    with address=hit_way in the same cycle. Stay in IDLE.
//   Miss: victim = lowest-index invalid way, else PLRU lruAddress. Latch victim and line address.
//    Clear valid[victim]. Go to FETCH, asserting fetch_req from the next cycle.
//  FETCH: each fetch_valid writes fetch_data to data[victim][beat_cnt], beat_cnt++. Beats arriving
//   without fetch_req are ignored. On the last beat (beat_cnt == 2^LINE_WORD_BITS-1): write tag,
//   set valid[victim], drop fetch_req next cycle, go to RESPOND.
//  RESPOND: cpu_rdata = data[victim][word]; cpu_ack=1; PLRU enable with address=victim; go to IDLE.
//  Miss latency: cpu_ack 1 cycle after the last fetch_valid beat.
//  Back-to-back: cpu_req still high in the ack cycle is the same request, not a new one.
//   A new request is sampled no earlier than 1 cycle after cpu_ack.
//  PLRU enable is asserted at most once per request; never during FETCH.
//  flush: in IDLE it clears all valid bits that cycle. If flush and cpu_req arrive in the same
//   cycle, flush wins; the request is looked up next cycle and misses.
//   In FETCH/RESPOND, flush is latched as pending. It is applied on entry to IDLE, after the ack,
//   so the freshly filled line is also invalidated.
//  Reset mid-fill: refill aborted immediately, fetch_req=0 next cycle, no ack, all lines invalid.
//   The flash engine shares rst.
//  No writes from the CPU side; the cache is read-only.
// STRUCTURE
//  flash_cache_pkg: state enum {IDLE,FETCH,RESPOND}, TAG_WIDTH/WORD_IDX helper functions.
//  Sub-module: the existing binary-tree PLRU block, SIZE=WAY_BITS, instance name plru.
//   Ports: enable, address = updated way, lruAddress = victim candidate.
//  Tag, valid and data arrays live in flops in this module; no further sub-modules.
// TESTING
//  1 Cold miss: req 0x000104 -> fetch_addr=0x000100, 4 beats 0xA0..0xA3 -> cpu_rdata=0xA1,
//    ack 1 cycle after beat 3.
//  2 Hit: repeat 0x00010C after test 1 -> cpu_rdata=0xA3, ack next cycle, no fetch_req.
//  3 Fill order: 8 misses to distinct lines -> ways 0..7 used in order (invalid-first).
//    Then touch way 0, then a 9th miss -> victim equals PLRU output and is not way 0.
//  4 Flush during FETCH: pending flush, ack still given with correct data.
//    Next req to the same line -> miss with fetch_req asserted again.
//  5 Reset on beat 2 of a fill -> fetch_req low next cycle, no ack.
//    Next req to that line misses.
//  6 Simultaneous flush + cpu_req hitting a valid line -> treated as a miss, line refetched.

Source files
------------

// File: rtl/flash_cache_pkg.sv
// rtl/flash_cache_pkg.sv - shared types and address helpers for the flash line cache
package flash_cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  function automatic int tag_width(input int addr_width, input int line_word_bits);
    return addr_width - line_word_bits - 2;
  endfunction

  // Word index within a line; the two byte-offset bits are dropped.
  function automatic int word_idx(input logic [31:0] addr, input int line_word_bits);
    return int'((addr >> 2) & ((32'd1 << line_word_bits) - 32'd1));
  endfunction

endpackage

// File: rtl/flash_cache_plru.sv
// rtl/flash_cache_plru.sv - binary-tree pseudo-LRU over 2**SIZE ways
module flash_cache_plru #(
  parameter int SIZE = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [SIZE-1:0] address,
  output logic [SIZE-1:0] lruAddress
);

  localparam int NODES = 1 << SIZE;

  // Heap-ordered tree, root at 1; a node bit of 1 means the right half is older.
  logic [NODES-1:1] tree;
  logic [NODES-1:1] tree_next;
  int               lru_node;
  int               upd_node;

  always_comb begin
    lru_node   = 1;
    lruAddress = '0;
    for (int lvl = 0; lvl < SIZE; lvl++) begin
      lruAddress[SIZE-1-lvl] = tree[lru_node];
      lru_node = 2 * lru_node + int'(tree[lru_node]);
    end
  end

  always_comb begin
    tree_next = tree;
    upd_node  = 1;
    for (int lvl = 0; lvl < SIZE; lvl++) begin
      tree_next[upd_node] = ~address[SIZE-1-lvl];
      upd_node = 2 * upd_node + int'(address[SIZE-1-lvl]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tree <= '0;
    end else if (enable) begin
      tree <= tree_next;
    end
  end

endmodule

// File: rtl/flash_cache_controller.sv
// rtl/flash_cache_controller.sv - fully associative read-only line cache in front of the flash fetch engine
module flash_cache_controller
  import flash_cache_pkg::*;
#(
  parameter int WAY_BITS       = 3,
  parameter int LINE_WORD_BITS = 2,
  parameter int ADDR_WIDTH     = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  flush,
  output logic                  fetch_req,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic [31:0]           fetch_data,
  input  logic                  fetch_valid,
  output logic                  busy
);

  localparam int NWAYS  = 1 << WAY_BITS;
  localparam int NWORDS = 1 << LINE_WORD_BITS;
  localparam int TAG_W  = tag_width(ADDR_WIDTH, LINE_WORD_BITS);
  localparam logic [LINE_WORD_BITS-1:0] LAST_BEAT = LINE_WORD_BITS'(NWORDS - 1);

  state_t                    state;
  logic [NWAYS-1:0]          valid;
  logic [TAG_W-1:0]          tags [NWAYS];
  logic [31:0]               data [NWAYS][NWORDS];
  logic [WAY_BITS-1:0]       victim;
  logic [TAG_W-1:0]          req_tag;
  logic [LINE_WORD_BITS-1:0] req_word;
  logic [LINE_WORD_BITS-1:0] beat_cnt;
  logic                      flush_pending;

  logic [TAG_W-1:0]          cur_tag;
  logic [LINE_WORD_BITS-1:0] cur_word;
  logic                      hit;
  logic [WAY_BITS-1:0]       hit_way;
  logic [WAY_BITS-1:0]       victim_sel;
  logic [WAY_BITS-1:0]       lru_way;
  logic                      accept;
  logic                      fill_beat;
  logic                      last_beat;
  logic                      plru_enable;
  logic [WAY_BITS-1:0]       plru_address;

  assign cur_tag  = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign cur_word = LINE_WORD_BITS'(word_idx(32'(cpu_addr), LINE_WORD_BITS));

  // While cpu_ack is high the CPU is still holding the request just answered.
  assign accept    = (state == IDLE) && cpu_req && !cpu_ack && !flush;
  assign fill_beat = !rst && (state == FETCH) && fetch_valid && fetch_req;
  assign last_beat = fill_beat && (beat_cnt == LAST_BEAT);

  assign fetch_addr = {req_tag, {(LINE_WORD_BITS + 2){1'b0}}};
  assign busy       = (state != IDLE);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = 0; i < NWAYS; i++) begin
      if (valid[i] && (tags[i] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(i);
      end
    end
  end

  // Lowest-index invalid way wins; the PLRU choice is only used when all ways are valid.
  always_comb begin
    victim_sel = lru_way;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim_sel = WAY_BITS'(i);
      end
    end
  end

  assign plru_enable  = (accept && hit) || (state == RESPOND);
  assign plru_address = (state == RESPOND) ? victim : hit_way;

  flash_cache_plru #(
    .SIZE(WAY_BITS)
  ) plru (
    .clk        (clk),
    .rst        (rst),
    .enable     (plru_enable),
    .address    (plru_address),
    .lruAddress (lru_way)
  );

  always_ff @(posedge clk) begin
    if (fill_beat) begin
      data[victim][beat_cnt] <= fetch_data;
    end
    if (last_beat) begin
      tags[victim] <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      cpu_ack       <= 1'b0;
      cpu_rdata     <= '0;
      fetch_req     <= 1'b0;
      flush_pending <= 1'b0;
      victim        <= '0;
      req_tag       <= '0;
      req_word      <= '0;
      beat_cnt      <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (accept) begin
            if (hit) begin
              cpu_rdata <= data[hit_way][cur_word];
              cpu_ack   <= 1'b1;
            end else begin
              victim             <= victim_sel;
              req_tag            <= cur_tag;
              req_word           <= cur_word;
              valid[victim_sel]  <= 1'b0;
              beat_cnt           <= '0;
              fetch_req          <= 1'b1;
              state              <= FETCH;
            end
          end
        end
        FETCH: begin
          if (flush) begin
            flush_pending <= 1'b1;
          end
          if (fill_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (last_beat) begin
            valid[victim] <= 1'b1;
            fetch_req     <= 1'b0;
            cpu_ack       <= 1'b1;
            // The requested word may be the one arriving on this very beat.
            cpu_rdata     <= (req_word == LAST_BEAT) ? fetch_data : data[victim][req_word];
            state         <= RESPOND;
          end
        end
        RESPOND: begin
          if (flush || flush_pending) begin
            valid <= '0;
          end
          flush_pending <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cache_controller.sv
// tb/tb_flash_cache_controller.sv - randomized self-checking bench with a reference cache model
module tb_flash_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [23:0] cpu_addr = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        flush = 1'b0;
  logic        fetch_req;
  logic [23:0] fetch_addr;
  logic [31:0] fetch_data = '0;
  logic        fetch_valid = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bit          m_valid [8];
  logic [19:0] m_tag   [8];
  int          m_last  [8];
  int          m_time;

  flash_cache_controller dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .flush       (flush),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] flash_word(input logic [23:0] line, input int i);
    if (line == 24'h000100) return 32'hA0 + 32'(i);
    return {8'h3C, line[23:4], 4'(i)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_last[i]  = 0;
    end
    m_time = 0;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endfunction

  // Tree PLRU victim: descend into the half whose most recent use is older.
  function automatic int plru_victim();
    int lo, size, ml, mr;
    lo = 0;
    size = 8;
    while (size > 1) begin
      size = size / 2;
      ml = 0;
      mr = 0;
      for (int i = 0; i < size; i++) begin
        if (m_last[lo + i] > ml) ml = m_last[lo + i];
        if (m_last[lo + size + i] > mr) mr = m_last[lo + size + i];
      end
      if (mr < ml) lo = lo + size;
    end
    return lo;
  endfunction

  function automatic void model_read(input logic [23:0] addr, output logic [31:0] exp_data,
                                     output bit exp_hit, output int exp_way);
    logic [19:0] t;
    t = addr[23:4];
    exp_hit = 1'b0;
    exp_way = -1;
    for (int i = 0; i < 8; i++)
      if (m_valid[i] && m_tag[i] == t) begin
        exp_hit = 1'b1;
        exp_way = i;
      end
    if (!exp_hit) begin
      for (int i = 7; i >= 0; i--) if (!m_valid[i]) exp_way = i;
      if (exp_way < 0) exp_way = plru_victim();
      m_valid[exp_way] = 1'b1;
      m_tag[exp_way]   = t;
    end
    m_time++;
    m_last[exp_way] = m_time;
    exp_data = flash_word({t, 4'h0}, int'(addr[3:2]));
  endfunction

  task automatic do_read(input logic [23:0] addr, input bit flush_first, input int flush_beat,
                         input bit hold, output logic [31:0] rdata, output bit acked,
                         output bit fetched, output logic [23:0] faddr, output int ack_cyc,
                         output int last_cyc, output logic [2:0] vict, output logic freq_at_ack);
    int beat, cyc;
    rdata = '0; acked = 1'b0; fetched = 1'b0; faddr = '0; ack_cyc = -1; last_cyc = -1;
    vict = '0; freq_at_ack = 1'b1; beat = 0; cyc = 0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    flush    = flush_first;
    while (!acked && cyc < 80) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      fetch_valid = 1'b0;
      if (cpu_ack) begin
        acked = 1'b1;
        rdata = cpu_rdata;
        ack_cyc = cyc;
        freq_at_ack = fetch_req;
      end else if (fetch_req && beat < 4) begin
        if (!fetched) begin
          fetched = 1'b1;
          faddr = fetch_addr;
          vict = dut.victim;
        end
        if (beat == flush_beat) flush = 1'b1;
        if ($urandom_range(0, 3) != 0) begin
          fetch_valid = 1'b1;
          fetch_data = flash_word(fetch_addr, beat);
          beat++;
          if (beat == 4) last_cyc = cyc;
        end
      end
    end
    if (!hold) cpu_req = 1'b0;
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_flush();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0 || fetch_req !== 1'b0 || cpu_rdata !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b freq=%b rdata=%h busy=%b want 0 0 0 0",
               cpu_ack, fetch_req, cpu_rdata, busy);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_cold_miss();
    logic [31:0] rd, ed; bit ack, fet, eh; logic [23:0] fa; int ac, lc, ew; logic [2:0] vo; logic fr;
    do_read(24'h000104, 1'b0, -1, 1'b0, rd, ack, fet, fa, ac, lc, vo, fr);
    model_read(24'h000104, ed, eh, ew);
    checks++;
    if (fa !== 24'h000100) begin errors++; $display("FAIL cold_fetch_addr got %h want 000100", fa); end
    checks++;
    if (!ack || rd !== 32'hA1) begin errors++; $display("FAIL cold_rdata got %h (ack %0d) want a1", rd, ack); end
    checks++;
    if (ac != lc + 1) begin errors++; $display("FAIL cold_latency ack at %0d want %0d", ac, lc + 1); end
    checks++;
    if (fr !== 1'b0) begin errors++; $display("FAIL cold_fetch_req_drop got %b want 0", fr); end
  endtask

  task automatic test_hit();
    logic [31:0] rd, ed; bit ack, fet, eh; logic [23:0] fa; int ac, lc, ew; logic [2:0] vo; logic fr;
    do_read(24'h00010C, 1'b0, -1, 1'b0, rd, ack, fet, fa, ac, lc, vo, fr);
    model_read(24'h00010C, ed, eh, ew);
    checks++;
    if (rd !== 32'hA3) begin errors++; $display("FAIL hit_rdata got %h want a3", rd); end
    checks++;
    if (fet || ac != 1) begin errors++; $display("FAIL hit_latency fetched=%0d ack_cyc=%0d want 0 1", fet, ac); end
  endtask

  task automatic test_fill_order();
    logic [31:0] rd, ed; bit ack, fet, eh; logic [23:0] fa, a; int ac, lc, ew; logic [2:0] vo; logic fr;
    flush_pulse();
    for (int i = 0; i < 8; i++) begin
      a = 24'h200000 | 24'(i << 4);
      do_read(a, 1'b0, -1, 1'b0, rd, ack, fet, fa, ac, lc, vo, fr);
      model_read(a, ed, eh, ew);
      checks++;
      if (!fet || int'(vo) != i || rd !== ed)
        begin errors++; $display("FAIL fill_way%0d got way %0d fetched %0d data %h want way %0d data %h", i, vo, fet, rd, i, ed); end
    end
    do_read(24'h200000, 1'b0, -1, 1'b0, rd, ack, fet, fa, ac, lc, vo, fr);
    model_read(24'h200000, ed, eh, ew);
    checks++;
    if (fet || rd !== ed) begin errors++; $display("FAIL touch_way0 fetched %0d data %h want 0 %h", fet, rd, ed); end
    do_read(24'h3F0008, 1'b0, -1, 1'b0, rd, ack, fet, fa, ac, lc, vo, fr);
    model_read(24'h3F0008, ed, eh, ew);
    checks++;
    if (!fet || int'(vo) != ew || vo == 3'd0 || rd !== ed)
      begin errors++; $display("FAIL plru_victim got way %0d data %h want way %0d data %h", vo, rd, ew, ed); end
  endtask

  task automatic test_flush_during_fetch();
    logic [31:0] rd, ed; bit ack, fet, eh; logic [23:0] fa; int ac, lc, ew; logic [2:0] vo; logic fr;
    do_read(24'h500008, 1'b0, 1, 1'b0, rd, ack, fet, fa, ac, lc, vo, fr);
    model_read(24'h500008, ed, eh, ew);
    model_flush();
    checks++;
    if (!ack || rd !== ed) begin errors++; $display("FAIL flush_fetch_ack data %h ack %0d want %h", rd, ack, ed); end
    do_read(24'h500004, 1'b0, -1, 1'b0, rd, ack, fet, fa, ac, lc, vo, fr);
    model_read(24'h500004, ed, eh, ew);
    checks++;
    if (!fet || rd !== ed) begin errors++; $display("FAIL flush_fetch_refetch fetched %0d data %h want 1 %h", fet, rd, ed); end
  endtask

  task automatic test_flush_with_req();
    logic [31:0] rd, ed; bit ack, fet, eh; logic [23:0] fa; int ac, lc, ew; logic [2:0] vo; logic fr;
    do_read(24'h610000, 1'b0, -1, 1'b0, rd, ack, fet, fa, ac, lc, vo, fr);
    model_read(24'h610000, ed, eh, ew);
    model_flush();
    do_read(24'h61000C, 1'b1, -1, 1'b0, rd, ack, fet, fa, ac, lc, vo, fr);
    model_read(24'h61000C, ed, eh, ew);
    checks++;
    if (!fet || rd !== ed) begin errors++; $display("FAIL flush_with_req fetched %0d data %h want 1 %h", fet, rd, ed); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ed; bit ack, fet, eh; logic [23:0] fa, a; int ac, lc, ew, extra; logic [2:0] vo; logic fr;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 24'h61000C : 24'h720004;
      do_read(a, 1'b0, -1, 1'b1, rd, ack, fet, fa, ac, lc, vo, fr);
      model_read(a, ed, eh, ew);
      extra = 0;
      @(negedge clk);
      if (cpu_ack) extra++;
      cpu_req = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (cpu_ack) extra++;
      end
      checks++;
      if (!ack || rd !== ed || extra != 0)
        begin errors++; $display("FAIL back_to_back%0d data %h extra_acks %0d want %h 0", k, rd, extra, ed); end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd, ed; bit ack, fet, eh; logic [23:0] fa; int ac, lc, ew, beat, cyc, acks; logic [2:0] vo; logic fr;
    flush_pulse();
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = 24'h730008;
    beat = 0;
    cyc = 0;
    while (beat < 3 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      fetch_valid = 1'b0;
      if (fetch_req) begin
        fetch_valid = 1'b1;
        fetch_data = flash_word(fetch_addr, beat);
        if (beat == 2) rst = 1'b1;
        beat++;
      end
    end
    @(negedge clk);
    fetch_valid = 1'b0;
    cpu_req = 1'b0;
    checks++;
    if (beat != 3 || fetch_req !== 1'b0 || cpu_ack !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL reset_mid_fill beats %0d freq %b ack %b busy %b want 3 0 0 0", beat, fetch_req, cpu_ack, busy); end
    rst = 1'b0;
    model_reset();
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL reset_no_ack got %0d acks want 0", acks); end
    do_read(24'h730008, 1'b0, -1, 1'b0, rd, ack, fet, fa, ac, lc, vo, fr);
    model_read(24'h730008, ed, eh, ew);
    checks++;
    if (!fet || rd !== ed) begin errors++; $display("FAIL reset_refetch fetched %0d data %h want 1 %h", fet, rd, ed); end
  endtask

  task automatic test_random();
    logic [31:0] rd, ed; bit ack, fet, eh, ff; logic [23:0] fa, a; int ac, lc, ew, fb, r; logic [2:0] vo; logic fr;
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 11);
      a  = 24'h400000 | 24'(r << 8) | 24'($urandom_range(0, 15));
      ff = ($urandom_range(0, 7) == 0);
      fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_read(a, ff, fb, 1'b0, rd, ack, fet, fa, ac, lc, vo, fr);
      if (ff) model_flush();
      model_read(a, ed, eh, ew);
      if (fb >= 0 && !eh) model_flush();
      checks++;
      if (!ack || rd !== ed || fet != !eh)
        begin errors++; $display("FAIL random%0d addr %h data %h fetched %0d want %h %0d", n, a, rd, fet, ed, !eh); end
      checks++;
      if (fet && (int'(vo) != ew || fa !== {a[23:4], 4'h0} || ac != lc + 1))
        begin errors++; $display("FAIL random_fill%0d way %0d faddr %h ack %0d want way %0d faddr %h ack %0d", n, vo, fa, ac, ew, {a[23:4], 4'h0}, lc + 1); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_fill_order();
    test_flush_during_fetch();
    test_flush_with_req();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
